// File: rtl/wb_pkg.sv
// Shared types and widths for the register write-back queue.
package wb_pkg;

   localparam int WB_ADDR_W = 3;
   localparam int WB_DATA_W = 8;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of write-back entries; also exposes its contents oldest-first
// so the top level can search for the youngest matching register.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  wb_entry_t                push_entry,
   input  logic                     pop,
   output wb_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output wb_entry_t [DEPTH-1:0]    age_entries,
   output logic [DEPTH-1:0]         age_valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   wb_entry_t        mem [DEPTH];

   // Pointers are exactly PTR_W bits wide, so the power-of-two depth makes
   // the increment wrap on its own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[tail_ptr] <= push_entry;
            tail_ptr      <= tail_ptr + 1'b1;
         end
         if (pop) begin
            head_ptr <= head_ptr + 1'b1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head = mem[head_ptr];

   // Index 0 is the oldest entry; valid entries form a prefix of length count.
   always_comb begin
      age_entries = '0;
      age_valid   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_entries[i] = mem[head_ptr + PTR_W'(i)];
         age_valid[i]   = (CNT_W'(i) < count);
      end
   end

endmodule

// File: rtl/reg_writeback.sv
// Register write-back queue: arbitrates ALU/load results into a FIFO, drains
// one write per cycle to the register file and answers pending-write lookups.
module reg_writeback
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   input  logic [ADDR_W-1:0]      alu_addr,
   input  logic [DATA_W-1:0]      alu_data,
   output logic                   alu_ready,
   input  logic                   mem_valid,
   input  logic [ADDR_W-1:0]      mem_addr,
   input  logic [DATA_W-1:0]      mem_data,
   output logic                   mem_ready,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic                   wr_enable,
   output logic [DATA_W-1:0]      wr_data,
   input  logic [ADDR_W-1:0]      lookup_addr,
   output logic                   lookup_hit,
   output logic [DATA_W-1:0]      lookup_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  full;
   logic                  alu_fire;
   logic                  mem_fire;
   logic                  push;
   wb_entry_t             push_entry;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] age_entries;
   logic [DEPTH-1:0]      age_valid;

   // Readiness looks only at the current count: a same-cycle pop never
   // frees a slot for a full queue.
   assign full      = (count == CNT_W'(DEPTH));
   assign alu_ready = !full;
   assign mem_ready = !full && !alu_valid;
   assign alu_fire  = alu_valid && alu_ready;
   assign mem_fire  = mem_valid && mem_ready;
   assign push      = alu_fire || mem_fire;

   always_comb begin
      push_entry = '0;
      if (alu_fire) begin
         push_entry.addr = alu_addr;
         push_entry.data = alu_data;
      end else begin
         push_entry.addr = mem_addr;
         push_entry.data = mem_data;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (wr_enable),
      .head        (head),
      .count       (count),
      .age_entries (age_entries),
      .age_valid   (age_valid)
   );

   assign wr_enable = (count != '0);
   assign wr_addr   = wr_enable ? head.addr : '0;
   assign wr_data   = wr_enable ? head.data : '0;

   // Scanning oldest to youngest lets the last match overwrite earlier ones,
   // so the entry nearest the tail supplies the data.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (age_valid[i] && (age_entries[i].addr == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = age_entries[i].data;
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;

   localparam int DEPTH = 4;

   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       alu_valid;
   logic [2:0] alu_addr;
   logic [7:0] alu_data;
   logic       alu_ready;
   logic       mem_valid;
   logic [2:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_ready;
   logic [2:0] wr_addr;
   logic       wr_enable;
   logic [7:0] wr_data;
   logic [2:0] lookup_addr;
   logic       lookup_hit;
   logic [7:0] lookup_data;
   logic [2:0] count;

   int numVectors     = 0;
   int numMiscompares = 0;

   ent_t        modelQ[$];
   logic [10:0] pushedLog[$];
   logic [10:0] writtenLog[$];

   reg_writeback #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_addr    (alu_addr),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .wr_addr     (wr_addr),
      .wr_enable   (wr_enable),
      .wr_data     (wr_data),
      .lookup_addr (lookup_addr),
      .lookup_hit  (lookup_hit),
      .lookup_data (lookup_data),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numVectors++;
      if (observed !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, compare every output
   // with the model, then advance the model at the rising edge.
   task automatic applyStimulus(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                                input logic mv, input logic [2:0] ma, input logic [7:0] md,
                                input logic [2:0] la);
      int         sz;
      logic       expHit;
      logic [7:0] expData;
      ent_t       e;
      @(negedge clk);
      alu_valid   = av;
      alu_addr    = aa;
      alu_data    = ad;
      mem_valid   = mv;
      mem_addr    = ma;
      mem_data    = md;
      lookup_addr = la;
      #1;
      sz = modelQ.size();
      checkOutput("wr_enable", wr_enable, (sz != 0));
      checkOutput("wr_addr",   wr_addr,   (sz != 0) ? modelQ[0].addr : 3'd0);
      checkOutput("wr_data",   wr_data,   (sz != 0) ? modelQ[0].data : 8'd0);
      checkOutput("count",     count,     sz);
      checkOutput("alu_ready", alu_ready, (sz != DEPTH));
      checkOutput("mem_ready", mem_ready, (sz != DEPTH) && !av);
      expHit  = 1'b0;
      expData = 8'd0;
      for (int i = sz - 1; i >= 0; i--) begin
         if (modelQ[i].addr == la) begin
            expHit  = 1'b1;
            expData = modelQ[i].data;
            break;
         end
      end
      checkOutput("lookup_hit",  lookup_hit,  expHit);
      checkOutput("lookup_data", lookup_data, expData);
      if (wr_enable) writtenLog.push_back({wr_addr, wr_data});
      @(posedge clk);
      if (sz != 0) void'(modelQ.pop_front());
      if (av && (sz != DEPTH)) begin
         e.addr = aa;
         e.data = ad;
         modelQ.push_back(e);
         pushedLog.push_back({aa, ad});
      end else if (mv && (sz != DEPTH)) begin
         e.addr = ma;
         e.data = md;
         modelQ.push_back(e);
         pushedLog.push_back({ma, md});
      end
   endtask

   task automatic idleCycle(input logic [2:0] la);
      applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, la);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      alu_valid   = 1'b0;
      alu_addr    = '0;
      alu_data    = '0;
      mem_valid   = 1'b1;
      mem_addr    = '0;
      mem_data    = '0;
      lookup_addr = '0;
      #1;
      checkOutput("rst_wr_enable", wr_enable, 0);
      checkOutput("rst_wr_addr",   wr_addr,   0);
      checkOutput("rst_wr_data",   wr_data,   0);
      checkOutput("rst_count",     count,     0);
      checkOutput("rst_lookup",    lookup_hit, 0);
      checkOutput("rst_alu_ready", alu_ready, 1);
      checkOutput("rst_mem_ready", mem_ready, 1);
      alu_valid = 1'b1;
      #1;
      checkOutput("rst_mem_ready_alu", mem_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      rst_n     = 1'b1;

      // Single ALU write with one-cycle latency
      applyStimulus(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'd0, 3'd0);
      #1;
      checkOutput("t1_wen",  wr_enable, 1);
      checkOutput("t1_addr", wr_addr,   3);
      checkOutput("t1_data", wr_data,   8'h5A);
      idleCycle(3'd3);
      #1;
      checkOutput("t1_wen_after", wr_enable, 0);
      checkOutput("t1_count",     count,     0);

      // ALU wins; load is held one cycle
      applyStimulus(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 3'd2);
      #1;
      checkOutput("t2_first_addr", wr_addr, 1);
      checkOutput("t2_first_data", wr_data, 8'h11);
      applyStimulus(1'b0, 3'd0, 8'd0, 1'b1, 3'd2, 8'h22, 3'd2);
      #1;
      checkOutput("t2_second_addr", wr_addr, 2);
      checkOutput("t2_second_data", wr_data, 8'h22);
      idleCycle(3'd0);

      // Back-to-back pushes on both ports: drain keeps pace so it never fills
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 3'(i), 8'(8'h40 + i), 1'b1, 3'(i + 4), 8'(8'h80 + i), 3'(i));
         #1;
         checkOutput("t3_count", count, 1);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd0, 8'd0, 1'b1, 3'(i + 4), 8'(8'h80 + i), 3'(i + 4));
      idleCycle(3'd0);

      // Youngest match supplies lookup data
      applyStimulus(1'b1, 3'd5, 8'h10, 1'b0, 3'd0, 8'd0, 3'd5);
      applyStimulus(1'b1, 3'd5, 8'h20, 1'b0, 3'd0, 8'd0, 3'd5);
      #1;
      checkOutput("t4_hit",  lookup_hit,  1);
      checkOutput("t4_data", lookup_data, 8'h20);
      idleCycle(3'd6);
      idleCycle(3'd5);

      // Ten pushes in a row wrap the pointers; all must emerge in order
      pushedLog.delete();
      writtenLog.delete();
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) applyStimulus(1'b1, 3'(i), 8'(8'hA0 + i), 1'b0, 3'd0, 8'd0, 3'(i));
         else            applyStimulus(1'b0, 3'd0, 8'd0, 1'b1, 3'(i), 8'(8'hA0 + i), 3'(i));
      end
      idleCycle(3'd0);
      idleCycle(3'd0);
      checkOutput("t5_num_writes", writtenLog.size(), 10);
      for (int i = 0; i < 10; i++) begin
         checkOutput("t5_order", (i < writtenLog.size()) ? writtenLog[i] : 11'h7FF,
                     {3'(i), 8'(8'hA0 + i)});
      end

      // Asynchronous reset with a write pending
      applyStimulus(1'b1, 3'd7, 8'hC3, 1'b0, 3'd0, 8'd0, 3'd7);
      @(negedge clk);
      #1;
      checkOutput("t6_wen_before", wr_enable, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_wen_async",  wr_enable,  0);
      checkOutput("t6_addr_async", wr_addr,    0);
      checkOutput("t6_count",      count,      0);
      checkOutput("t6_lookup",     lookup_hit, 0);
      modelQ.delete();
      @(posedge clk);
      @(negedge clk);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      rst_n     = 1'b1;
      idleCycle(3'd7);
      idleCycle(3'd7);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 99) < 45), 3'($urandom), 8'($urandom),
                       ($urandom_range(0, 99) < 55), 3'($urandom), 8'($urandom),
                       3'($urandom));
      end
      idleCycle(3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
